// File: rtl/regfile_pkg.sv
// Shared register-file definitions: geometry constants and the transfer state encoding
// used by both the write-side file and the serial reader.
package regfile_pkg;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = $clog2(NUM_REGS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/piso_shift_16.sv
// 16-bit parallel-in serial-out register: load wins over shift, shifts left so the
// word leaves MSB first.
module piso_shift_16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        shift,
    input  logic [15:0] din,
    output logic        msb
);

    logic [15:0] sreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= din;
        end else if (shift) begin
            sreg <= {sreg[14:0], 1'b0};
        end
    end

    assign msb = sreg[15];

endmodule

// File: rtl/regfile_serial_reader.sv
// Walks a wrapping range of register-file addresses, snapshots each word in a FETCH
// cycle and streams it MSB-first over a bit-serial valid/ready link.
module regfile_serial_reader
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W:0]   num,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              tx_bit,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_last,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0]   MAX_WORDS = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W:0]   ONE_WORD  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);
    localparam logic [3:0]        TOP_BIT   = 4'(DATA_W - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   words_q;
    logic [3:0]        bit_q;
    logic              load;
    logic              handshake;
    logic              msb;

    assign load      = (state == FETCH);
    assign handshake = (state == SHIFT) && tx_ready;

    piso_shift_16 u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (handshake),
        .din   (rd_data),
        .msb   (msb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            words_q <= '0;
            bit_q   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_q  <= first_addr;
                        words_q <= (num > MAX_WORDS) ? MAX_WORDS : num;
                    end
                end
                FETCH: bit_q <= TOP_BIT;
                SHIFT: begin
                    if (tx_ready) begin
                        bit_q <= bit_q - 4'd1;
                        if (bit_q == 4'd0) begin
                            words_q <= words_q - ONE_WORD;
                            addr_q  <= addr_q + ONE_ADDR;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // The last handshake of the last word skips FETCH and goes straight to DONE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (num == '0) ? DONE : FETCH;
            FETCH:   state_nxt = SHIFT;
            SHIFT:   if (tx_ready && bit_q == 4'd0)
                         state_nxt = (words_q == ONE_WORD) ? DONE : FETCH;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign rd_addr  = addr_q;
    assign tx_valid = (state == SHIFT);
    assign tx_bit   = tx_valid & msb;
    assign tx_last  = tx_valid && (words_q == ONE_WORD) && (bit_q == 4'd0);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

endmodule

// File: tb/tb_regfile_serial_reader.sv
// Directed bench for regfile_serial_reader: a behavioural register file feeds rd_data,
// each run records the bitstream and timing, and results are compared to hand values.
module tb_regfile_serial_reader;
    import regfile_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] first_addr;
    logic [ADDR_W:0]   num;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              tx_bit;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_last;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] regs [NUM_REGS];

    always #5 clk = ~clk;

    assign rd_data = regs[rd_addr];

    regfile_serial_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .first_addr (first_addr),
        .num        (num),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .tx_bit     (tx_bit),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_last    (tx_last),
        .busy       (busy),
        .done       (done)
    );

    int checks   = 0;
    int failures = 0;

    // Per-run hooks, indexed by cycle number after the start edge (0 = unused)
    int                restartCycle, rstCycle, wc1, wc2;
    logic [ADDR_W-1:0] wa1, wa2;
    logic [DATA_W-1:0] wd1, wd2;
    bit                toggleReady;

    // Per-run observations
    int           doneCycle, doneCount, nbits, lastCount, lastCycle;
    int           gapCount, firstValid, unstable, validAfterRst;
    logic         busyC1, busyAfter;
    logic [127:0] stream;
    logic [31:0]  addrSeq;
    logic [8:0]   zeroAfterRst;

    task automatic checkOutput(input string tag, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic clearHooks();
        restartCycle = 0;
        rstCycle     = 0;
        wc1          = 0;
        wc2          = 0;
        wa1          = '0;
        wa2          = '0;
        wd1          = '0;
        wd2          = '0;
        toggleReady  = 1'b0;
    endtask

    // Issues one start and watches the link for at most 'limit' cycles
    task automatic applyStimulus(input logic [ADDR_W-1:0] fa, input logic [ADDR_W:0] n,
                                 input int limit);
        logic heldBit;
        logic stalled;
        heldBit       = 1'b0;
        stalled       = 1'b0;
        doneCycle     = -1;
        doneCount     = 0;
        nbits         = 0;
        lastCount     = 0;
        lastCycle     = -1;
        gapCount      = 0;
        firstValid    = -1;
        unstable      = 0;
        validAfterRst = 0;
        busyC1        = 1'bx;
        busyAfter     = 1'bx;
        stream        = '0;
        addrSeq       = '0;
        zeroAfterRst  = 9'h1FF;
        @(negedge clk);
        first_addr = fa;
        num        = n;
        start      = 1'b1;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            start = (c == restartCycle);
            if (start) begin
                first_addr = '0;
                num        = 4'd8;
            end
            rst = (c == rstCycle);
            if (c == wc1) regs[wa1] = wd1;
            if (c == wc2) regs[wa2] = wd2;
            tx_ready = toggleReady ? c[0] : 1'b1;
            #1;
            if (c == 1) busyC1 = busy;
            if (stalled && (!tx_valid || tx_bit !== heldBit)) unstable++;
            stalled = tx_valid && !tx_ready;
            heldBit = tx_bit;
            if (tx_valid && firstValid < 0) firstValid = c;
            if (busy && !tx_valid && !done) begin
                addrSeq = {addrSeq[27:0], 1'b0, rd_addr};
                if (firstValid > 0) gapCount++;
            end
            if (tx_valid && tx_ready) begin
                stream = {stream[126:0], tx_bit};
                nbits++;
            end
            if (tx_last) begin
                lastCount++;
                lastCycle = c;
            end
            if (done) begin
                doneCount++;
                if (doneCycle < 0) doneCycle = c;
            end
            if (rstCycle > 0 && c == rstCycle + 1)
                zeroAfterRst = {rd_addr, tx_bit, tx_valid, tx_last, busy, done};
            if (rstCycle > 0 && c > rstCycle && tx_valid) validAfterRst++;
            if (doneCycle > 0 && c == doneCycle + 1) begin
                busyAfter = busy;
                break;
            end
        end
        start    = 1'b0;
        rst      = 1'b0;
        tx_ready = 1'b1;
    endtask

    initial begin
        logic [127:0] expStream;
        rst        = 1'b1;
        start      = 1'b0;
        first_addr = '0;
        num        = '0;
        tx_ready   = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) regs[i] = '0;
        clearHooks();

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_rd_addr", 128'(rd_addr), 128'd0);
        checkOutput("rst_tx_bit", 128'(tx_bit), 128'd0);
        checkOutput("rst_tx_valid", 128'(tx_valid), 128'd0);
        checkOutput("rst_tx_last", 128'(tx_last), 128'd0);
        checkOutput("rst_busy", 128'(busy), 128'd0);
        checkOutput("rst_done", 128'(done), 128'd0);
        rst = 1'b0;

        // One word from reg3
        regs[3] = 16'hA5C3;
        clearHooks();
        applyStimulus(3'd3, 4'd1, 60);
        checkOutput("one_stream", stream[15:0], 16'hA5C3);
        checkOutput("one_nbits", nbits, 16);
        checkOutput("one_first_valid", firstValid, 2);
        checkOutput("one_last_cycle", lastCycle, 17);
        checkOutput("one_last_count", lastCount, 1);
        checkOutput("one_done_cycle", doneCycle, 18);
        checkOutput("one_done_count", doneCount, 1);
        checkOutput("one_busy_c1", 128'(busyC1), 128'd1);
        checkOutput("one_busy_after", 128'(busyAfter), 128'd0);

        // Wrap from reg7 through reg0 and reg1
        regs[7] = 16'h0001;
        regs[0] = 16'h8000;
        regs[1] = 16'hFFFF;
        clearHooks();
        applyStimulus(3'd7, 4'd3, 100);
        checkOutput("wrap_stream", stream[47:0], 48'h0001_8000_FFFF);
        checkOutput("wrap_nbits", nbits, 48);
        checkOutput("wrap_gaps", gapCount, 2);
        checkOutput("wrap_addrs", addrSeq[11:0], 12'h701);
        checkOutput("wrap_last_cycle", lastCycle, 51);
        checkOutput("wrap_done_cycle", doneCycle, 52);

        // Backpressure: ready only on odd cycles
        regs[4] = 16'h1234;
        clearHooks();
        toggleReady = 1'b1;
        applyStimulus(3'd4, 4'd1, 100);
        checkOutput("bp_stream", stream[15:0], 16'h1234);
        checkOutput("bp_nbits", nbits, 16);
        checkOutput("bp_unstable", unstable, 0);
        checkOutput("bp_last_count", lastCount, 2);
        checkOutput("bp_done_cycle", doneCycle, 34);

        // Snapshot: reg2 overwritten mid-shift, reg3 before its fetch
        regs[2] = 16'h1357;
        regs[3] = 16'h2468;
        clearHooks();
        wc1 = 5;  wa1 = 3'd2; wd1 = 16'hFFFF;
        wc2 = 10; wa2 = 3'd3; wd2 = 16'h0F0F;
        applyStimulus(3'd2, 4'd2, 100);
        checkOutput("snap_stream", stream[31:0], 32'h1357_0F0F);
        checkOutput("snap_done_cycle", doneCycle, 35);

        // num = 0
        clearHooks();
        applyStimulus(3'd6, 4'd0, 20);
        checkOutput("zero_done_cycle", doneCycle, 1);
        checkOutput("zero_busy_c1", 128'(busyC1), 128'd1);
        checkOutput("zero_nbits", nbits, 0);
        checkOutput("zero_first_valid", firstValid, -1);
        checkOutput("zero_busy_after", 128'(busyAfter), 128'd0);

        // num = 15 saturates to all 8 registers, starting at reg5
        for (int i = 0; i < NUM_REGS; i++) regs[i] = 16'h1010 * 16'(i + 1) ^ 16'h5A00;
        expStream = '0;
        for (int k = 0; k < NUM_REGS; k++)
            expStream = {expStream[111:0], regs[(5 + k) % NUM_REGS]};
        clearHooks();
        applyStimulus(3'd5, 4'd15, 300);
        checkOutput("sat_stream", stream, expStream);
        checkOutput("sat_nbits", nbits, 128);
        checkOutput("sat_addrs", addrSeq, 32'h5670_1234);
        checkOutput("sat_done_cycle", doneCycle, 137);

        // start while busy, then start during the DONE cycle
        regs[6] = 16'hBEEF;
        clearHooks();
        restartCycle = 5;
        applyStimulus(3'd6, 4'd1, 60);
        checkOutput("restart_busy_stream", stream[15:0], 16'hBEEF);
        checkOutput("restart_busy_done", doneCycle, 18);
        checkOutput("restart_busy_count", doneCount, 1);
        clearHooks();
        restartCycle = 18;
        applyStimulus(3'd6, 4'd1, 60);
        checkOutput("restart_done_cycle", doneCycle, 18);
        checkOutput("restart_done_idle", 128'(busyAfter), 128'd0);

        // Reset mid-word aborts without a done pulse
        regs[3] = 16'hA5C3;
        clearHooks();
        rstCycle = 6;
        applyStimulus(3'd3, 4'd1, 40);
        checkOutput("abort_outputs", zeroAfterRst, 9'd0);
        checkOutput("abort_valid", validAfterRst, 0);
        checkOutput("abort_done", doneCount, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_serial_reader.md
# regfile_serial_reader

Read-side companion to the register file's 16-bit write-enabled registers. On a start pulse it walks a contiguous, wrapping range of register addresses. It samples each register through the file's combinational read port and streams every word out MSB-first, one bit per handshake, over a bit-serial valid/ready link. It sits between the register file and the debug/scan link, and gives the system a way to dump register contents without stalling the write side.

## Interface
- NUM_REGS, 8, number of registers in the file (power of two)
- ADDR_W, 3, log2(NUM_REGS)
- DATA_W, 16, register width; fixed at 16 for this revision
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset rst, synchronous, active-high; clock clk
- start  input  1  single-cycle request; accepted only in IDLE
- first_addr  input  ADDR_W  first register to read; sampled with start
- num  input  ADDR_W+1  number of registers to read; sampled with start
- rd_addr  output  ADDR_W  read address to register file
- rd_data  input  DATA_W  combinational read data for rd_addr, valid same cycle
- tx_bit  output  1  current serial bit
- tx_valid  output  1  tx_bit is valid
- tx_ready  input  1  link accepts the bit when tx_valid && tx_ready
- tx_last  output  1  high with the final bit (bit 0) of the final word
- busy  output  1  transfer in progress
- done  output  1  one-cycle completion pulse

## Operation
- States: IDLE, FETCH, SHIFT, DONE.
- IDLE: busy=0, tx_valid=0.
  - start=1 latches first_addr into the address counter.
  - start=1 latches min(num, NUM_REGS) into the words-remaining counter.
  - Next state is FETCH, or DONE if num==0.
- FETCH, one cycle:
  - rd_addr = address counter.
  - rd_data is captured into the 16-bit shift register at the clock edge.
  - Bit counter is set to 15.
  - Next state is SHIFT.
- SHIFT:
  - tx_valid=1 and tx_bit = shift_reg[15].
  - On handshake, shift left by one and decrement the bit counter.
  - On the handshake with bit counter 0, decrement words-remaining and increment the address modulo NUM_REGS.
  - If words-remaining was 1, go to DONE; otherwise go to FETCH.
  - tx_ready low stalls: tx_bit, tx_valid and all counters hold.
- DONE, one cycle: done=1, busy=1, tx_valid=0. Next state is IDLE.
- Snapshot semantics:
  - A word is frozen at its FETCH cycle.
  - Writes to a register after its fetch do not alter the bits in flight.
  - Writes to a not-yet-fetched register are reflected.
- start outside IDLE, including in the DONE cycle, is ignored. No queuing.
- tx_last = tx_valid && (words-remaining==1) && (bit counter==0).

## Timing
- Reset values of every output:
  - rd_addr=0, tx_bit=0, tx_valid=0, tx_last=0, busy=0, done=0.
  - State is IDLE and all counters are 0.
- rst mid-transfer aborts on the next edge:
  - tx_valid drops immediately after that edge.
  - No done pulse is produced.
- Cycle 0: start. Cycle 1: FETCH, busy=1. Cycle 2: first bit valid.
- With tx_ready held high, each word costs 17 cycles (1 FETCH + 16 SHIFT).
- A transfer of N words has done at cycle 17N+1 after start.
- Between words, tx_valid is low for exactly the one FETCH cycle.
- num==0 gives busy in cycle 1 (DONE) and done in cycle 1, with no link activity.
- num>NUM_REGS saturates to NUM_REGS; no register is sent twice.
- Address wraps, e.g. first_addr=7, num=3 reads registers 7, 0, 1.

## Structure
- Shared package regfile_pkg holds:
  - constants DATA_W=16, NUM_REGS, ADDR_W;
  - the state enum (IDLE, FETCH, SHIFT, DONE), used by both this block and the write-side file.
- One sub-module: piso_shift_16, a 16-bit parallel-load, shift-left register with load and shift enables. The FSM and counters live in the top.

## Test plan
- Reset, then a one-word read:
  - Stimulus: preload reg3=0xA5C3; start with first_addr=3, num=1; tx_ready=1.
  - Required: bits 1010_0101_1100_0011 appear in cycles 2–17.
  - Required: tx_last=1 in cycle 17 only, done=1 in cycle 18, busy=0 in cycle 19.
- Wrap-around:
  - Stimulus: reg7=0x0001, reg0=0x8000, reg1=0xFFFF; first_addr=7, num=3.
  - Required: 48 bits in order 0x0001, 0x8000, 0xFFFF.
  - Required: tx_valid low for the one FETCH cycle between words.
- Backpressure:
  - Stimulus: toggle tx_ready every other cycle while reading 0x1234.
  - Required: the bitstream is unchanged, and tx_bit is stable whenever tx_valid && !tx_ready.
  - Required: done arrives 16 stall cycles later than with tx_ready held high.
- Snapshot:
  - Stimulus: read regs 2–3; write reg2=0xFFFF mid-shift of reg2 and reg3=0x0F0F before reg3's FETCH.
  - Required: the original reg2 value is sent, followed by 0x0F0F.
- Edge cases:
  - num=0 gives a done pulse in cycle 1 and no tx_valid.
  - num=15 sends 8 words.
  - start while busy is ignored.
  - rst asserted mid-word gives all outputs 0 next cycle and no done.
